// File: rtl/dram_burst_ctrl_pkg.sv
// dram_burst_ctrl_pkg: shared FSM state type and default geometry for the DRAM burst controller
package dram_burst_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, XFER, RESP} state_t;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_BEAT_W = 64;
  localparam int DEF_BURST_LEN = 4;
endpackage

// File: rtl/dram_burst_ctrl_line_buf.sv
// burst_line_buf: beat-indexed line register with write-beat mux, read-beat capture and committed read line
module burst_line_buf
  import dram_burst_ctrl_pkg::*;
#(
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [BURST_LEN*BEAT_W-1:0] load_line,
  input  logic                        we,
  input  logic                        beat,
  input  logic                        commit,
  input  logic [BEAT_W-1:0]           rdata_beat,
  output logic [BEAT_W-1:0]           wdata_beat,
  output logic [BURST_LEN*BEAT_W-1:0] rdata_line
);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int IW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  logic [BURST_LEN-1:0][BEAT_W-1:0] line_q, resp_q;
  logic [BURST_LEN-1:0] filled;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic full, cap;
  assign full = cnt == CW'(BURST_LEN);
  assign idx = full ? IW'(BURST_LEN - 1) : cnt[IW-1:0];
  assign cap = beat && !full && !we;
  assign wdata_beat = line_q[idx];
  assign rdata_line = resp_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      filled <= '0;
      line_q <= '0;
      resp_q <= '0;
    end else begin
      if (load) begin
        cnt <= '0;
        filled <= '0;
        line_q <= load_line;
      end else if (beat && !full) begin
        cnt <= cnt + 1'b1;
      end
      if (cap) begin
        line_q[idx] <= rdata_beat;
        filled[idx] <= 1'b1;
      end
      if (commit)
        for (int i = 0; i < BURST_LEN; i++)
          if (cap && idx == IW'(i)) resp_q[i] <= rdata_beat;
          else if (filled[i]) resp_q[i] <= line_q[i];
    end
  end
endmodule

// File: rtl/dram_burst_ctrl.sv
// dram_burst_ctrl: single-outstanding DRAM row burst controller; define DRAM_BURST_CTRL_TIMEOUT_EN to add the watchdog
module dram_burst_ctrl
  import dram_burst_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [BURST_LEN*BEAT_W-1:0] req_wdata,
  output logic                        resp_valid,
  output logic [BURST_LEN*BEAT_W-1:0] resp_rdata,
  output logic                        resp_err,
  output logic [ADDR_W-1:0]           dram_addr,
  output logic                        dram_read_en,
  output logic                        dram_write_en,
  output logic [BEAT_W-1:0]           dram_wdata,
  input  logic                        dram_ready,
  input  logic                        dram_complete,
  input  logic [BEAT_W-1:0]           dram_rdata,
  input  logic                        dram_valid
);
  state_t state, nxt;
  logic we_q, accept, to;
  assign accept = req_valid & req_ready;
  assign resp_valid = state == RESP;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? ISSUE : IDLE;
      ISSUE:   nxt = to ? RESP : dram_ready ? XFER : ISSUE;
      XFER:    nxt = (to || dram_complete) ? RESP : XFER;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b0;
      dram_read_en <= 1'b0;
      dram_write_en <= 1'b0;
      dram_addr <= '0;
      we_q <= 1'b0;
    end else begin
      state <= nxt;
      req_ready <= nxt == IDLE;
      dram_read_en <= nxt == XFER && !we_q;
      dram_write_en <= nxt == XFER && we_q;
      if (accept) begin
        dram_addr <= req_addr;
        we_q <= req_we;
      end
    end
  end
`ifdef DRAM_BURST_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;
  logic err_q;
  assign to = (state == ISSUE || state == XFER) && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign resp_err = resp_valid & err_q;
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) tcnt <= '0;
    else if (state == ISSUE || state == XFER) tcnt <= tcnt + 1'b1;
    if (rst || accept) err_q <= 1'b0;
    else if (to) err_q <= 1'b1;
  end
`else
  assign to = 1'b0;
  assign resp_err = 1'b0;
`endif
  burst_line_buf #(.BEAT_W(BEAT_W), .BURST_LEN(BURST_LEN)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_line  (req_wdata),
    .we         (we_q),
    .beat       (dram_valid && state == XFER),
    .commit     (state == XFER && dram_complete && !to && !we_q),
    .rdata_beat (dram_rdata),
    .wdata_beat (dram_wdata),
    .rdata_line (resp_rdata)
  );
endmodule

// File: tb/tb_dram_burst_ctrl.sv
// tb_dram_burst_ctrl: scoreboard bench for dram_burst_ctrl covering reads, writes, stalls, overrun, reset and timeout
module tb_dram_burst_ctrl;
  localparam int AW = 16;
  localparam int BW = 64;
  localparam int BL = 4;
  localparam int TO = 16;
  typedef logic [BL*BW-1:0] line_t;
  typedef struct packed {logic err; line_t data;} resp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid, req_ready, req_we, resp_valid, resp_err;
  logic [AW-1:0] req_addr, dram_addr;
  line_t req_wdata, resp_rdata;
  logic dram_read_en, dram_write_en, dram_ready, dram_complete, dram_valid;
  logic [BW-1:0] dram_wdata, dram_rdata;
  resp_t rq[$];
  logic [BW-1:0] wq[$];
  resp_t e;
  logic [BW-1:0] ew;
  line_t model_line = '0;
  line_t mem [logic [AW-1:0]];
  int checks = 0;
  int failures = 0;
  int resps = 0;
  int exp_resps = 0;
  always #5 clk = ~clk;
  dram_burst_ctrl #(.ADDR_W(AW), .BEAT_W(BW), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dram_addr(dram_addr), .dram_read_en(dram_read_en),
    .dram_write_en(dram_write_en), .dram_wdata(dram_wdata), .dram_ready(dram_ready),
    .dram_complete(dram_complete), .dram_rdata(dram_rdata), .dram_valid(dram_valid)
  );
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      resps++;
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp resp_valid=1 required=0");
      end else begin
        e = rq.pop_front();
        if ({resp_err, resp_rdata} !== e) begin
          failures++;
          $display("FAIL resp got err=%0b data=%h required err=%0b data=%h", resp_err, resp_rdata, e.err, e.data);
        end
      end
    end
    if (!rst && dram_valid && dram_write_en) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_wbeat dram_wdata=%h", dram_wdata);
      end else begin
        ew = wq.pop_front();
        if (dram_wdata !== ew) begin
          failures++;
          $display("FAIL wbeat got %h required %h", dram_wdata, ew);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic we, input logic [AW-1:0] a, input line_t l);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_wait got %b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = l;
    step();
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL accept_ready got %b required 0", req_ready);
    end
  endtask
  task automatic grant();
    dram_ready = 1'b1;
    step();
    dram_ready = 1'b0;
  endtask
  task automatic xfer(input logic we, input logic [AW-1:0] a, input logic [8*BW-1:0] bl, input int n);
    line_t tmp = '0;
    for (int i = 0; i < n; i++) begin
      dram_valid = 1'b1;
      dram_rdata = bl[i*BW+:BW];
      checks++;
      if (dram_read_en !== !we || dram_write_en !== we || dram_addr !== a) begin
        failures++;
        $display("FAIL hold got rd=%b wr=%b addr=%h required rd=%b wr=%b addr=%h", dram_read_en, dram_write_en, dram_addr, !we, we, a);
      end
      if (we && i < BL) tmp[i*BW+:BW] = dram_wdata;
      step();
    end
    dram_valid = 1'b0;
    dram_complete = 1'b1;
    checks++;
    if (dram_read_en !== !we || dram_write_en !== we) begin
      failures++;
      $display("FAIL hold_complete got rd=%b wr=%b required rd=%b wr=%b", dram_read_en, dram_write_en, !we, we);
    end
    step();
    dram_complete = 1'b0;
    checks++;
    if ({dram_read_en, dram_write_en, resp_valid} !== 3'b001) begin
      failures++;
      $display("FAIL drop got rd=%b wr=%b resp_valid=%b required 0 0 1", dram_read_en, dram_write_en, resp_valid);
    end
    if (we) mem[a] = tmp;
    step();
  endtask
  task automatic do_read(input logic [AW-1:0] a, input logic [8*BW-1:0] bl, input int n);
    for (int i = 0; i < n && i < BL; i++) model_line[i*BW+:BW] = bl[i*BW+:BW];
    rq.push_back({1'b0, model_line});
    exp_resps++;
    issue(1'b0, a, '0);
    grant();
    xfer(1'b0, a, bl, n);
  endtask
  task automatic do_write(input logic [AW-1:0] a, input line_t l);
    rq.push_back({1'b0, model_line});
    exp_resps++;
    for (int i = 0; i < BL; i++) wq.push_back(l[i*BW+:BW]);
    issue(1'b1, a, l);
    grant();
    xfer(1'b1, a, '0, BL);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    {req_valid, req_we, dram_ready, dram_complete, dram_valid} = '0;
    req_addr = '0;
    req_wdata = '0;
    dram_rdata = '0;
    step();
    step();
    checks++;
    if ({req_ready, resp_valid, resp_err, dram_read_en, dram_write_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got %b required 00000", {req_ready, resp_valid, resp_err, dram_read_en, dram_write_en});
    end
    checks++;
    if (resp_rdata !== '0 || dram_addr !== '0 || dram_wdata !== '0) begin
      failures++;
      $display("FAIL reset_data got rdata=%h addr=%h wdata=%h required 0", resp_rdata, dram_addr, dram_wdata);
    end
    rst = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b required 1", req_ready);
    end
  endtask
  task automatic test_read();
    logic [8*BW-1:0] bl = '0;
    for (int i = 0; i < 4; i++) bl[i*BW+:BW] = BW'(17 * (i + 1));
    do_read(16'h0005, bl, 4);
  endtask
  task automatic test_write_readback();
    line_t wl;
    logic [8*BW-1:0] bl = '0;
    wl = {64'hD, 64'hC, 64'hB, 64'hA};
    do_write(16'h0003, wl);
    checks++;
    if (mem[16'h0003] !== wl) begin
      failures++;
      $display("FAIL write_line got %h required %h", mem[16'h0003], wl);
    end
    bl[BL*BW-1:0] = mem[16'h0003];
    do_read(16'h0003, bl, 4);
  endtask
  task automatic test_stall();
    logic [8*BW-1:0] bl = '0;
    for (int i = 0; i < 4; i++) bl[i*BW+:BW] = BW'(64'hC0 + i);
    for (int i = 0; i < 4; i++) model_line[i*BW+:BW] = bl[i*BW+:BW];
    rq.push_back({1'b0, model_line});
    exp_resps++;
    issue(1'b0, 16'h0007, '0);
    for (int i = 0; i < 10; i++) begin
      {dram_valid, dram_complete, req_valid, req_we} = 4'b1111;
      dram_rdata = '1;
      req_addr = 16'hFFFF;
      checks++;
      if ({dram_read_en, dram_write_en, req_ready} !== 3'b000) begin
        failures++;
        $display("FAIL stall got rd=%b wr=%b ready=%b required 0 0 0", dram_read_en, dram_write_en, req_ready);
      end
      step();
    end
    {dram_valid, dram_complete, req_valid, req_we} = 4'b0000;
    grant();
    xfer(1'b0, 16'h0007, bl, 4);
  endtask
  task automatic test_overrun();
    logic [8*BW-1:0] bl = '0;
    for (int i = 0; i < 6; i++) bl[i*BW+:BW] = BW'(64'hA1 + i);
    do_read(16'h0011, bl, 6);
  endtask
  task automatic test_partial();
    logic [8*BW-1:0] bl = '0;
    bl[BW-1:0] = 64'hB1;
    bl[2*BW-1:BW] = 64'hB2;
    do_read(16'h0012, bl, 2);
  endtask
  task automatic test_reset_mid();
    logic [8*BW-1:0] bl = '0;
    issue(1'b0, 16'h0009, '0);
    grant();
    dram_valid = 1'b1;
    dram_rdata = 64'h55;
    step();
    dram_rdata = 64'h66;
    rst = 1'b1;
    step();
    checks++;
    if ({dram_read_en, dram_write_en, resp_valid, req_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset got rd=%b wr=%b resp=%b ready=%b required 0000", dram_read_en, dram_write_en, resp_valid, req_ready);
    end
    checks++;
    if (resp_rdata !== '0) begin
      failures++;
      $display("FAIL mid_reset_rdata got %h required 0", resp_rdata);
    end
    rst = 1'b0;
    dram_valid = 1'b0;
    model_line = '0;
    repeat (5) step();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready got %b required 1", req_ready);
    end
    for (int i = 0; i < 4; i++) bl[i*BW+:BW] = BW'(64'h71 + i);
    do_read(16'h000A, bl, 4);
  endtask
`ifdef DRAM_BURST_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    rq.push_back({1'b1, model_line});
    exp_resps++;
    dram_ready = 1'b1;
    issue(1'b0, 16'h0020, '0);
    while (resp_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    dram_ready = 1'b0;
    checks++;
    if (n !== TO) begin
      failures++;
      $display("FAIL timeout_cycles got %0d required %0d", n, TO);
    end
    checks++;
    if ({resp_err, dram_read_en, dram_write_en} !== 3'b100) begin
      failures++;
      $display("FAIL timeout_state got err=%b rd=%b wr=%b required 1 0 0", resp_err, dram_read_en, dram_write_en);
    end
    step();
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_read();
    test_write_readback();
    test_stall();
    test_overrun();
    test_partial();
    test_reset_mid();
`ifdef DRAM_BURST_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) step();
    checks++;
    if (resps !== exp_resps || rq.size() != 0 || wq.size() != 0) begin
      failures++;
      $display("FAIL resp_count got %0d pending=%0d/%0d required %0d 0/0", resps, rq.size(), wq.size(), exp_resps);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
